// File: rtl/flag_pkg.sv
// Shared types for the flag unit: the packed flag word, condition codes and
// the condition evaluator used by branch decisions.
package flag_pkg;

    typedef struct packed {
        logic z;
        logic o;
        logic c;
        logic s;
    } flags_t;

    typedef enum logic [3:0] {
        COND_AL  = 4'd0,
        COND_EQ  = 4'd1,
        COND_NE  = 4'd2,
        COND_CS  = 4'd3,
        COND_CC  = 4'd4,
        COND_MI  = 4'd5,
        COND_PL  = 4'd6,
        COND_VS  = 4'd7,
        COND_VC  = 4'd8,
        COND_UGT = 4'd9,
        COND_ULE = 4'd10,
        COND_SGE = 4'd11,
        COND_SLT = 4'd12,
        COND_SGT = 4'd13,
        COND_SLE = 4'd14,
        COND_NV  = 4'd15
    } cond_e;

    localparam logic [3:0] WMASK_ALL = 4'b1111;

    function automatic logic evalCond(input cond_e cc, input flags_t f);
        logic res;
        res = 1'b0;
        case (cc)
            COND_AL:  res = 1'b1;
            COND_EQ:  res = f.z;
            COND_NE:  res = !f.z;
            COND_CS:  res = f.c;
            COND_CC:  res = !f.c;
            COND_MI:  res = f.s;
            COND_PL:  res = !f.s;
            COND_VS:  res = f.o;
            COND_VC:  res = !f.o;
            COND_UGT: res = f.c && !f.z;
            COND_ULE: res = !f.c || f.z;
            COND_SGE: res = (f.s == f.o);
            COND_SLT: res = (f.s != f.o);
            COND_SGT: res = !f.z && (f.s == f.o);
            COND_SLE: res = f.z || (f.s != f.o);
            COND_NV:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_unit_if.sv
// Bus between the ALU/control unit (master) and the flag unit (slave).
interface flag_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             carry;
    logic             we;
    logic [3:0]       wmask;
    logic             load;
    logic [3:0]       load_val;
    logic             push;
    logic             pop;
    logic [3:0]       cond;
    logic             cond_true;
    logic             zflag;
    logic             oflag;
    logic             cflag;
    logic             sflag;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output result, overflow, carry, we, wmask, load, load_val, push, pop, cond,
        input  cond_true, zflag, oflag, cflag, sflag, count, full, empty, err
    );

    modport slave (
        input  result, overflow, carry, we, wmask, load, load_val, push, pop, cond,
        output cond_true, zflag, oflag, cflag, sflag, count, full, empty, err
    );

endinterface

// File: rtl/flag_stack.sv
// Register-based LIFO of flag words with occupancy count and a sticky
// misuse flag (push when full, pop when empty, or push+pop when empty).
module flag_stack
    import flag_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type data_t = flags_t,
    parameter int  CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  data_t            din,
    output data_t            dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err
);
    localparam int IDX_W = $clog2(DEPTH);

    data_t            stack_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             wrEn;
    logic [IDX_W-1:0] wrIdx;
    logic [IDX_W-1:0] topIdx;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign topIdx = IDX_W'(count_q - 1'b1);
    assign dout   = stack_q[topIdx];
    assign count  = count_q;
    assign err    = err_q;

    // A swap (push+pop with data present) overwrites the top in place.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        wrEn    = 1'b0;
        wrIdx   = IDX_W'(count_q);
        if (push && pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                wrEn  = 1'b1;
                wrIdx = topIdx;
            end
        end else if (push) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                wrEn    = 1'b1;
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            stack_q[wrIdx] <= din;
        end
    end

endmodule

// File: rtl/flag_unit.sv
// Z/O/C/S flag register with per-flag write enables, a LIFO flag stack and
// a combinational condition-code evaluator for branch decisions.
module flag_unit
    import flag_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input logic        clk,
    input logic        rst,
    flag_unit_if.slave bus
);
    flags_t flags_q, flags_d;
    flags_t aluFlags;
    flags_t stackTop;
    logic   stackEmpty;
    logic   popValid;

    flag_stack #(
        .DEPTH  (DEPTH),
        .data_t (flags_t),
        .CNT_W  (CNT_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push),
        .pop   (bus.pop),
        .din   (flags_q),
        .dout  (stackTop),
        .count (bus.count),
        .full  (bus.full),
        .empty (stackEmpty),
        .err   (bus.err)
    );

    assign bus.empty = stackEmpty;
    assign popValid  = bus.pop && !stackEmpty;

    assign aluFlags.z = (bus.result == '0);
    assign aluFlags.o = bus.overflow;
    assign aluFlags.c = bus.carry;
    assign aluFlags.s = bus.result[WIDTH-1];

    // Source priority: a pop that actually delivers data, then load, then ALU write.
    always_comb begin
        flags_d = flags_q;
        if (popValid) begin
            flags_d = stackTop;
        end else if (bus.load) begin
            flags_d = flags_t'(bus.load_val);
        end else if (bus.we) begin
            flags_d = (aluFlags & bus.wmask) | (flags_q & ~bus.wmask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.zflag     = flags_q.z;
    assign bus.oflag     = flags_q.o;
    assign bus.cflag     = flags_q.c;
    assign bus.sflag     = flags_q.s;
    assign bus.cond_true = evalCond(cond_e'(bus.cond), flags_q);

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit with WIDTH=16, DEPTH=4.
module tb_flag_unit;
    import flag_pkg::*;

    logic clk;
    logic rst;
    int   passCount;
    int   checkCount;

    flag_unit_if #(.WIDTH(16), .DEPTH(4)) bus ();

    flag_unit #(.WIDTH(16), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] curFlags();
        return {4'b0, bus.zflag, bus.oflag, bus.cflag, bus.sflag};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one cycle of inputs, waits for the edge, then drops the strobes.
    task automatic applyStimulus(input logic w, input logic [3:0] m, input logic [15:0] r,
                                 input logic ov, input logic cy, input logic ld,
                                 input logic [3:0] lv, input logic ps, input logic pp);
        bus.we       = w;
        bus.wmask    = m;
        bus.result   = r;
        bus.overflow = ov;
        bus.carry    = cy;
        bus.load     = ld;
        bus.load_val = lv;
        bus.push     = ps;
        bus.pop      = pp;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
        bus.load = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic loadFlags(input logic [3:0] v);
        applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic pushOp();
        applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic popOp();
        applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] condExp;
        passCount  = 0;
        checkCount = 0;
        rst          = 1'b1;
        bus.result   = '0;
        bus.overflow = 1'b0;
        bus.carry    = 1'b0;
        bus.we       = 1'b0;
        bus.wmask    = 4'h0;
        bus.load     = 1'b0;
        bus.load_val = 4'h0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.cond     = 4'd0;

        #2;
        checkOutput("reset_flags", curFlags(), 8'h00);
        checkOutput("reset_count", 8'(bus.count), 8'd0);
        checkOutput("reset_empty", 8'(bus.empty), 8'd1);
        checkOutput("reset_full", 8'(bus.full), 8'd0);
        checkOutput("reset_err", 8'(bus.err), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero/sign/overflow/carry capture
        applyStimulus(1'b1, WMASK_ALL, 16'h8000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("we_8000", curFlags(), 8'h05);
        applyStimulus(1'b1, WMASK_ALL, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("we_zero", curFlags(), 8'h08);

        // Per-flag mask: only C written
        loadFlags(4'hF);
        checkOutput("load_all", curFlags(), 8'h0F);
        applyStimulus(1'b1, 4'b0010, 16'h0005, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("mask_c_only", curFlags(), 8'h0D);

        loadFlags(4'b0010);
        bus.cond = 4'd9;
        #1;
        checkOutput("ugt_c1_z0", 8'(bus.cond_true), 8'd1);

        // Full condition table on z=1 o=0 c=1 s=0
        loadFlags(4'b1010);
        condExp = 16'h4D4B;
        for (int i = 0; i < 16; i++) begin
            bus.cond = 4'(i);
            #1;
            checkOutput($sformatf("cond%0d_1010", i), 8'(bus.cond_true), 8'(condExp[i]));
        end

        // Full condition table on z=0 o=1 c=0 s=1
        loadFlags(4'b0101);
        condExp = 16'h2CB5;
        for (int i = 0; i < 16; i++) begin
            bus.cond = 4'(i);
            #1;
            checkOutput($sformatf("cond%0d_0101", i), 8'(bus.cond_true), 8'(condExp[i]));
        end
        bus.cond = 4'd0;

        // Fill the stack with four distinct words (load rides alongside push)
        loadFlags(4'b0001);
        applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0);
        checkOutput("push1_count", 8'(bus.count), 8'd1);
        applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0);
        checkOutput("full_count", 8'(bus.count), 8'd4);
        checkOutput("full_flag", 8'(bus.full), 8'd1);
        checkOutput("full_err", 8'(bus.err), 8'd0);
        checkOutput("full_flags", curFlags(), 8'h0F);

        pushOp();
        checkOutput("overpush_err", 8'(bus.err), 8'd1);
        checkOutput("overpush_count", 8'(bus.count), 8'd4);

        popOp();
        checkOutput("pop1_flags", curFlags(), 8'h08);
        checkOutput("pop1_count", 8'(bus.count), 8'd3);
        popOp();
        checkOutput("pop2_flags", curFlags(), 8'h04);
        popOp();
        checkOutput("pop3_flags", curFlags(), 8'h02);
        popOp();
        checkOutput("pop4_flags", curFlags(), 8'h01);
        checkOutput("pop4_empty", 8'(bus.empty), 8'd1);
        popOp();
        checkOutput("underpop_flags", curFlags(), 8'h01);
        checkOutput("underpop_err", 8'(bus.err), 8'd1);
        checkOutput("underpop_count", 8'(bus.count), 8'd0);

        // Clear err before the swap section
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("pulse_rst_err", 8'(bus.err), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Swap with data present
        loadFlags(4'b1000);
        pushOp();
        checkOutput("swap_pre_count", 8'(bus.count), 8'd1);
        loadFlags(4'b0011);
        applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        checkOutput("swap_flags", curFlags(), 8'h08);
        checkOutput("swap_count", 8'(bus.count), 8'd1);
        checkOutput("swap_err", 8'(bus.err), 8'd0);
        popOp();
        checkOutput("swap_top", curFlags(), 8'h03);

        // Swap on an empty stack: error, load still honoured
        applyStimulus(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b1);
        checkOutput("swap0_err", 8'(bus.err), 8'd1);
        checkOutput("swap0_count", 8'(bus.count), 8'd0);
        checkOutput("swap0_flags", curFlags(), 8'h06);

        // Priority: valid pop beats load and we
        pushOp();
        loadFlags(4'b1001);
        applyStimulus(1'b1, WMASK_ALL, 16'h0000, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
        checkOutput("prio_pop", curFlags(), 8'h06);
        checkOutput("prio_pop_count", 8'(bus.count), 8'd0);

        // Load beats we
        applyStimulus(1'b1, WMASK_ALL, 16'h0000, 1'b1, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b0);
        checkOutput("prio_load", curFlags(), 8'h05);

        // push+we: stack gets the old flags, flags get the ALU result
        applyStimulus(1'b1, WMASK_ALL, 16'h8000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("pushwe_flags", curFlags(), 8'h03);
        checkOutput("pushwe_count", 8'(bus.count), 8'd1);
        popOp();
        checkOutput("pushwe_stacked", curFlags(), 8'h05);

        // Asynchronous reset between edges
        pushOp();
        pushOp();
        pushOp();
        checkOutput("pre_rst_count", 8'(bus.count), 8'd3);
        checkOutput("pre_rst_err", 8'(bus.err), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_flags", curFlags(), 8'h00);
        checkOutput("async_rst_count", 8'(bus.count), 8'd0);
        checkOutput("async_rst_err", 8'(bus.err), 8'd0);
        checkOutput("async_rst_empty", 8'(bus.empty), 8'd1);
        #2;
        rst = 1'b0;

        loadFlags(4'b1001);
        pushOp();
        checkOutput("post_rst_count", 8'(bus.count), 8'd1);
        loadFlags(4'b0000);
        popOp();
        checkOutput("post_rst_pop", curFlags(), 8'h09);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Parametrised successor to the single-register ALU compare/flag latch.
- Holds the Z/O/C/S flags for a WIDTH-bit datapath and gives each flag its own write enable.
- Adds a DEPTH-entry LIFO flag stack, so flags survive calls and interrupts.
- Adds a 4-bit condition-code evaluator that drives branch decisions in the control unit.

Parameters:
- WIDTH, 8, datapath width of the compared result.
- DEPTH, 4, flag-stack entries (≥2).
- CNT_W, $clog2(DEPTH+1), width of the stack occupancy count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- result  in  WIDTH  ALU result to evaluate.
- overflow  in  1  ALU signed-overflow.
- carry  in  1  ALU carry-out (1 = no borrow on subtract).
- we  in  1  update flags from result/overflow/carry.
- wmask  in  4  per-flag enable for we, order {z,o,c,s}.
- load  in  1  write flags directly from load_val.
- load_val  in  4  {z,o,c,s} value for load.
- push  in  1  push current flags onto the stack.
- pop  in  1  pop the top of stack into the flags.
- cond  in  4  condition-code select.
- cond_true  out  1  combinational result of cond on the current flag registers.
- zflag, oflag, cflag, sflag  out  1 each  registered flags.
- count  out  CNT_W  stack occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- err  out  1  sticky: push when full, or pop when empty.

Behaviour:
- Reset (async, immediate): all flags 0, count 0, err 0, stack contents don't-care. Outputs after reset: empty=1, full=0.
- Flag write, when we=1 and the wmask bit is set:
  - z <= (result=={WIDTH{0}})
  - s <= result[WIDTH-1]
  - o <= overflow
  - c <= carry
  - Flags with a cleared mask bit hold their value.
- Flag-source priority per cycle: valid pop > load > we. The lower-priority sources are ignored that cycle.
- Latency: one cycle. Flags are visible the cycle after the write edge.
- push stores the pre-edge flag register value into entry[count]; count is incremented.
  - push and we in the same cycle: the stack receives the old flags, and the flags take the new ALU values.
- pop loads entry[count-1] into the flags; count is decremented.
- push and pop in the same cycle with count>0 is a swap:
  - the top entry becomes the current flags;
  - the flags become the old top;
  - count is unchanged.
- push and pop in the same cycle with count==0: err<=1, nothing else changes, and we/load are still honoured.
- push when full (pop=0): ignored, err<=1, the stack is not overwritten.
- pop when empty (push=0): ignored, err<=1, the flags follow load/we.
- err stays set until rst.
- cond mapping, evaluated combinationally from the current registers:
  - 0 always, 1 eq Z, 2 ne !Z, 3 cs C, 4 cc !C, 5 mi S, 6 pl !S, 7 vs O
  - 8 vc !O, 9 ugt C&!Z, 10 ule !C|Z, 11 sge S==O, 12 slt S!=O
  - 13 sgt !Z&(S==O), 14 sle Z|(S!=O), 15 never
- Stack storage is plain registers; there is no memory macro.

Decomposition:
- Package flag_pkg holds:
  - typedef flags_t, a packed struct {z,o,c,s};
  - enum cond_e with the 16 condition codes;
  - the constant WMASK_ALL = 4'b1111.
- Sub-module flag_stack holds:
  - the LIFO, count, full/empty and err;
  - parameters DEPTH and the flags_t data type;
  - ports push, pop, din, dout, count, full, empty, err.
- flag_unit keeps the flag register, the priority mux and the cond decoder.

Test Plan:
- Zero/sign with WIDTH=16: we=1, wmask=F, result=16'h8000, overflow=1, carry=0 → next cycle z=0, s=1, o=1, c=0. Then result=0 → z=1, s=0.
- Mask: flags={1,1,1,1}, we=1, wmask=4'b0010 (c only), result=5, carry=0 → z,o,s stay 1 and c=0. Also cond=9 (ugt) with C=1, Z=0 gives cond_true=1, and with Z=1 gives 0.
- Stack with DEPTH=4:
  - push 4 different flag sets → full=1, count=4;
  - a 5th push → err=1, count=4, contents unchanged;
  - 4 pops return the sets in LIFO order, then empty=1;
  - a 5th pop → err stays 1, flags unchanged.
- Swap: push {1,0,0,0}, set flags {0,0,1,1} via load, assert push+pop together → flags={1,0,0,0}, top={0,0,1,1}, count=1. Same stimulus with count=0 → err=1, count=0.
- Priority: pop=1, load=1, we=1 together with count=1 → flags equal the popped value. Repeat with push+we → the stack holds the old flags and the flags hold the ALU values.
- Reset mid-operation: assert rst asynchronously between edges while count=3 and err=1 → all flags, count and err go to 0 immediately, empty=1. After release, normal pushes resume.
